alu_issue_stage: RTL

Producer end of the ALU operand interface. Sits between decode and the combinational ALU: it resolves forwarding, selects the immediate, decodes the 4-bit ALU control code, and registers operands and control into a 2-entry skid buffer with valid/ready handshakes on both sides. Its `Mux1Out`, `Mux2Out` and `ALUControl` outputs drive the ALU directly.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_issue_stage_if.sv | 39 +++
 rtl/alu_ctrl_decode.sv | 36 +++
 rtl/alu_issue_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: control codes, operand-select
// encodings, function-field constants, skid FSM states and the held-beat record.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0110,
    ALU_OR  = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_XOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_sel_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } skid_state_e;

  // One resolved ALU beat as held in a skid slot.
  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    alu_ctrl_e         ctrl;
    logic              illegal;
  } beat_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and ALU-side signals of the issue stage.
// master: the issue stage itself; slave: decode/forwarding/EX-MEM environment.
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] RegA;
  logic [DATA_W-1:0] RegB;
  logic [DATA_W-1:0] Imm;
  logic              ALUSrc;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic [DATA_W-1:0] ExMemResult;
  logic [DATA_W-1:0] MemWbResult;
  logic [1:0]        ALUOp;
  logic [2:0]        Funct3;
  logic              Funct7b5;
  logic              Flush;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] Mux1Out;
  logic [DATA_W-1:0] Mux2Out;
  logic [3:0]        ALUControl;
  logic              IllegalOp;

  modport master (
    input  InValid, RegA, RegB, Imm, ALUSrc, ForwardA, ForwardB, ExMemResult, MemWbResult,
    input  ALUOp, Funct3, Funct7b5, Flush, OutReady,
    output InReady, OutValid, Mux1Out, Mux2Out, ALUControl, IllegalOp
  );

  modport slave (
    output InValid, RegA, RegB, Imm, ALUSrc, ForwardA, ForwardB, ExMemResult, MemWbResult,
    output ALUOp, Funct3, Funct7b5, Flush, OutReady,
    input  InReady, OutValid, Mux1Out, Mux2Out, ALUControl, IllegalOp
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/Funct3/Funct7b5 -> ALU control code decoder.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_ctrl_e  alu_ctrl_o,
  output logic       illegal_o
);

  // Decode the control code; unsupported functions fall back to add and flag illegal.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    unique case (alu_op_e'(alu_op_i))
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3_i)
          // I-type has no subtract form, so funct7b5 only matters for R-type.
          F3_ADD:  alu_ctrl_o = (alu_op_i == ALUOP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
          F3_OR:   alu_ctrl_o = ALU_OR;
          F3_AND:  alu_ctrl_o = ALU_AND;
          F3_XOR:  alu_ctrl_o = ALU_XOR;
          default: begin
            alu_ctrl_o = ALU_ADD;
            illegal_o  = 1'b1;
          end
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: forwarding/immediate operand muxes, control decode and a
// 2-entry skid buffer with registered InReady toward decode.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst_n,
  alu_issue_stage_if.master  bus
);

  skid_state_e state_q, state_d;
  beat_t       main_q, main_d;
  beat_t       skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  beat_t       in_beat;
  alu_ctrl_e   dec_ctrl;
  logic        dec_illegal;
  logic        accept;

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic [DATA_W-1:0] exmem_val,
                                                input logic [DATA_W-1:0] memwb_val);
    logic [DATA_W-1:0] res;
    case (fwd_sel_e'(sel))
      FWD_EXMEM: res = exmem_val;
      FWD_MEMWB: res = memwb_val;
      default:   res = reg_val;  // reserved select reads the register file
    endcase
    return res;
  endfunction

  alu_ctrl_decode u_decode (
    .alu_op_i   (bus.ALUOp),
    .funct3_i   (bus.Funct3),
    .funct7b5_i (bus.Funct7b5),
    .alu_ctrl_o (dec_ctrl),
    .illegal_o  (dec_illegal)
  );

  assign accept = bus.InValid & in_ready_q;

  // Resolve the incoming beat from decode-side inputs; only used on accept.
  always_comb begin
    in_beat.op_a    = fwd_mux(bus.ForwardA, bus.RegA, bus.ExMemResult, bus.MemWbResult);
    in_beat.op_b    = bus.ALUSrc ? bus.Imm
                                 : fwd_mux(bus.ForwardB, bus.RegB, bus.ExMemResult,
                                           bus.MemWbResult);
    in_beat.ctrl    = dec_ctrl;
    in_beat.illegal = dec_illegal;
  end

  // Skid FSM next state and slot loads.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && bus.OutReady) begin
          main_d = in_beat;
        end else if (accept) begin
          skid_d  = in_beat;
          state_d = StTwo;
        end else if (bus.OutReady) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (bus.OutReady) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops everything held, including a beat accepted this cycle.
    if (bus.Flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d  = (state_d != StTwo);
    out_valid_d = (state_d != StEmpty);
  end

  // State, slots and registered handshake outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StEmpty;
      main_q      <= beat_t'('0);
      skid_q      <= beat_t'('0);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ALU-facing outputs come straight from the main slot.
  always_comb begin
    bus.InReady    = in_ready_q;
    bus.OutValid   = out_valid_q;
    bus.Mux1Out    = main_q.op_a;
    bus.Mux2Out    = main_q.op_b;
    bus.ALUControl = main_q.ctrl;
    bus.IllegalOp  = main_q.illegal & out_valid_q;
  end

endmodule
